// File: rtl/rot_seq_pkg.sv
// Shared types and default sizes for the rotation sequencer and its per-wheel trackers.
package rot_seq_pkg;

    localparam int unsigned ROT_NUM_WHEELS = 4;
    localparam int unsigned ROT_ANGLE_W    = 12;
    localparam int unsigned ROT_TMO_W      = 24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_DONE,
        RES_FAIL,
        RES_TMO
    } resolve_t;

endpackage

// File: rtl/rot_wheel_tracker.sv
// Per-wheel guard and timeout counters; flags the cycle an active wheel resolves and why.
module rot_wheel_tracker
    import rot_seq_pkg::*;
#(
    parameter int unsigned TMO_W      = ROT_TMO_W,
    parameter int unsigned DONE_GUARD = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             active,
    input  logic [TMO_W-1:0] timeout_cycles,
    input  logic             angle_done,
    input  logic             startup_fail,
    output logic             resolve,
    output resolve_t         reason
);

    localparam int unsigned GUARD_W = (DONE_GUARD > 0) ? $clog2(DONE_GUARD + 1) : 1;

    logic [GUARD_W-1:0] guard_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               guard_open;

    // The timeout count is loaded with 1 so that it equals the number of active cycles elapsed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            guard_cnt <= '0;
            tmo_cnt   <= '0;
        end else if (start) begin
            guard_cnt <= GUARD_W'(DONE_GUARD);
            tmo_cnt   <= TMO_W'(1);
        end else if (active) begin
            if (guard_cnt != '0)
                guard_cnt <= guard_cnt - GUARD_W'(1);
            if (tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign guard_open = (guard_cnt == '0);

    always_comb begin
        reason = RES_NONE;
        if (active) begin
            if (startup_fail)
                reason = RES_FAIL;
            else if (guard_open && angle_done)
                reason = RES_DONE;
            else if (guard_open && (timeout_cycles != '0) && (tmo_cnt >= timeout_cycles))
                reason = RES_TMO;
        end
    end

    assign resolve = (reason != RES_NONE);

endmodule

// File: rtl/rotation_sequencer.sv
// Dispatches a multi-wheel rotation set with at most MAX_ACTIVE wheels moving at once.
// Optional ROT_SEQ_STAGGER_EN enforces a STAGGER_CYCLES gap between dispatches.
module rotation_sequencer
    import rot_seq_pkg::*;
#(
    parameter int unsigned NUM_WHEELS     = ROT_NUM_WHEELS,
    parameter int unsigned MAX_ACTIVE     = 2,
    parameter int unsigned ANGLE_W        = ROT_ANGLE_W,
    parameter int unsigned TMO_W          = ROT_TMO_W,
    parameter int unsigned DONE_GUARD     = 4,
    parameter int unsigned STAGGER_CYCLES = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [NUM_WHEELS*ANGLE_W-1:0] req_angles,
    input  logic [NUM_WHEELS-1:0]         req_mask,
    input  logic [TMO_W-1:0]              timeout_cycles,
    input  logic                          abort_all,
    output logic [NUM_WHEELS*ANGLE_W-1:0] target_angle,
    output logic [NUM_WHEELS-1:0]         angle_update,
    output logic [NUM_WHEELS-1:0]         abort_angle,
    input  logic [NUM_WHEELS-1:0]         angle_done,
    input  logic [NUM_WHEELS-1:0]         startup_fail,
    output logic                          seq_busy,
    output logic                          seq_done,
    output logic                          seq_aborted,
    output logic [NUM_WHEELS-1:0]         wheel_fail,
    output logic [NUM_WHEELS-1:0]         timeout_err
);

    if (MAX_ACTIVE < 1 || MAX_ACTIVE > NUM_WHEELS || STAGGER_CYCLES < 1) begin : g_bad_cfg
        $error("rotation_sequencer: invalid MAX_ACTIVE or STAGGER_CYCLES");
    end

    seq_state_t              state;
    logic [NUM_WHEELS-1:0]   pending;
    logic [NUM_WHEELS-1:0]   active;
    logic [TMO_W-1:0]        tmo_q;
    logic [NUM_WHEELS-1:0]   pick;
    logic [NUM_WHEELS-1:0]   dispatch;
    logic [NUM_WHEELS-1:0]   res_strobe;
    logic [NUM_WHEELS-1:0]   fail_hit;
    logic [NUM_WHEELS-1:0]   tmo_hit;
    resolve_t                res_reason [NUM_WHEELS];
    logic                    accept;
    logic                    gap_ok;
    int unsigned             act_cnt;

    assign accept = req_valid && req_ready;

    always_comb begin
        act_cnt = 0;
        for (int unsigned i = 0; i < NUM_WHEELS; i++)
            act_cnt += 32'(active[i]);
    end

    // Isolate the lowest set pending bit.
    assign pick     = pending & (~pending + NUM_WHEELS'(1));
    assign dispatch = (state == RUN && !abort_all && act_cnt < MAX_ACTIVE && gap_ok) ? pick : '0;

    assign angle_update = dispatch;
    assign abort_angle  = (state != RUN) ? '0 : (abort_all ? active : tmo_hit);
    assign seq_busy     = (state != IDLE);
    assign seq_done     = (state == FINISH);

    for (genvar g = 0; g < NUM_WHEELS; g++) begin : g_wheel
        rot_wheel_tracker #(
            .TMO_W      (TMO_W),
            .DONE_GUARD (DONE_GUARD)
        ) u_tracker (
            .clock          (clock),
            .reset          (reset),
            .start          (dispatch[g]),
            .active         (active[g]),
            .timeout_cycles (tmo_q),
            .angle_done     (angle_done[g]),
            .startup_fail   (startup_fail[g]),
            .resolve        (res_strobe[g]),
            .reason         (res_reason[g])
        );
        assign fail_hit[g] = (res_reason[g] == RES_FAIL);
        assign tmo_hit[g]  = (res_reason[g] == RES_TMO);
    end

`ifdef ROT_SEQ_STAGGER_EN
    localparam int unsigned GAP_W = $clog2(STAGGER_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            gap_cnt <= '0;
        else if (accept || (state == RUN && abort_all))
            gap_cnt <= '0;
        else if (dispatch != '0)
            gap_cnt <= GAP_W'(STAGGER_CYCLES);
        else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GAP_W'(1);
    end

    assign gap_ok = (gap_cnt == '0);
`else
    assign gap_ok = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            pending      <= '0;
            active       <= '0;
            tmo_q        <= '0;
            target_angle <= '0;
            seq_aborted  <= 1'b0;
            wheel_fail   <= '0;
            timeout_err  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        for (int unsigned i = 0; i < NUM_WHEELS; i++)
                            if (req_mask[i])
                                target_angle[i*ANGLE_W +: ANGLE_W] <= req_angles[i*ANGLE_W +: ANGLE_W];
                        pending     <= req_mask;
                        active      <= '0;
                        tmo_q       <= timeout_cycles;
                        wheel_fail  <= '0;
                        timeout_err <= '0;
                        seq_aborted <= 1'b0;
                        state       <= (req_mask == '0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (abort_all) begin
                        pending     <= '0;
                        active      <= '0;
                        seq_aborted <= 1'b1;
                        state       <= DRAIN;
                    end else begin
                        pending     <= pending & ~dispatch;
                        active      <= (active & ~res_strobe) | dispatch;
                        wheel_fail  <= wheel_fail | fail_hit;
                        timeout_err <= timeout_err | tmo_hit;
                        if (pending == '0 && active == '0)
                            state <= FINISH;
                    end
                end
                DRAIN: state <= FINISH;
                FINISH: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
